// File: rtl/digits_pkg.sv
// Shared definitions for the key encoder.
//   DEBOUNCE_CYCLES_DEFAULT : default number of stable samples to accept a press/release
//   state_t                 : key encoder FSM state encoding
package digits_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_two.sv
// Two-stage synchronizer for the 4 raw key lines.
//   clk   : sampling clock
//   rst_n : async active-low reset, clears both stages
//   d     : asynchronous input lines
//   q     : synchronized output (two clocks of latency)
module sync_two (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Debounced 4-key encoder with valid/ready hand-off.
//   clk   : single clock, rising edge
//   rst_n : async active-low reset
//   keys  : raw bouncing key lines, bit i high = key i pressed
//   ready : consumer accepts the presented code
//   code  : index of highest pressed key in the accepted pattern
//   valid : code/multi are presented, held until ready
//   multi : more than one key set in the accepted pattern
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no key seen, waiting for a non-zero synchronized sample
// DEBOUNCE | counting consecutive identical samples of pat
// PRESENT  | event presented (valid=1), waiting for ready
// RELEASE  | event consumed, waiting for all keys released and stable
module key_encoder
  import digits_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keys,
  input  logic       ready,
  output logic [1:0] code,
  output logic       valid,
  output logic       multi
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state, state_nxt;
  logic [3:0]    ks;
  logic [3:0]    pat, pat_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    code_nxt;
  logic          valid_nxt;
  logic          multi_nxt;
  logic [1:0]    enc_code;
  logic [2:0]    enc_ones;
  logic          enc_multi;

  sync_two u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (keys),
    .q     (ks)
  );

  // Priority encode (3 > 2 > 1 > 0) and popcount of the debounced pattern.
  always_comb begin
    enc_code = 2'd0;
    if (pat[3])      enc_code = 2'd3;
    else if (pat[2]) enc_code = 2'd2;
    else if (pat[1]) enc_code = 2'd1;
    enc_ones  = 3'(pat[0]) + 3'(pat[1]) + 3'(pat[2]) + 3'(pat[3]);
    enc_multi = (enc_ones > 3'd1);
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    code_nxt  = code;
    valid_nxt = valid;
    multi_nxt = multi;
    unique case (state)
      IDLE: begin
        if (ks != 4'd0) begin
          pat_nxt   = ks;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks == 4'd0) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (ks != pat) begin
          // Pattern changed mid-debounce: restart on the new pattern.
          pat_nxt = ks;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          code_nxt  = enc_code;
          multi_nxt = enc_multi;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESENT: begin
        // Keys are ignored here so a release cannot disturb the event.
        if (ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (ks != 4'd0) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat   <= '0;
      cnt   <= '0;
      code  <= 2'b00;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      multi <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder with DEBOUNCE_CYCLES=4.
module tb_key_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys;
  logic       ready;
  logic [1:0] code;
  logic       valid;
  logic       multi;

  int total = 0;
  int bad   = 0;
  int ev    = 0;
  logic pv  = 1'b0;

  // Behavioural model state: run-length view of the synchronized samples.
  logic [3:0] m_s1 = 0, m_s2 = 0, m_runv = 0;
  int         m_run = 0, m_zrun = 0;
  logic       m_armed = 1'b1;
  logic       m_valid = 1'b0, m_multi = 1'b0;
  logic [1:0] m_code = 2'b00;

  key_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (keys),
    .ready (ready),
    .code  (code),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] top_bit(input logic [3:0] p);
    top_bit = 2'd0;
    for (int i = 0; i < 4; i++) if (p[i]) top_bit = 2'(i);
  endfunction

  // Model: an event fires once D+1 identical non-zero samples arrive while armed;
  // after the hand-off, D consecutive zero samples re-arm it.
  initial begin : model
    logic [3:0] s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 0; m_s2 = 0; m_runv = 0; m_run = 0; m_zrun = 0;
        m_armed = 1'b1; m_valid = 1'b0; m_code = 2'b00; m_multi = 1'b0;
      end else begin
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = keys;
        if (m_valid) begin
          if (ready) begin
            m_valid = 1'b0;
            m_zrun  = 0;
          end
        end else if (m_armed) begin
          if (s == 4'd0) begin
            m_run = 0; m_runv = 0;
          end else if (s == m_runv) begin
            m_run++;
          end else begin
            m_runv = s; m_run = 1;
          end
          if (m_run == D + 1) begin
            m_valid = 1'b1;
            m_code  = top_bit(s);
            m_multi = ($countones(s) > 1);
            m_armed = 1'b0;
            m_run   = 0;
            m_runv  = 0;
          end
        end else begin
          if (s == 4'd0) m_zrun++;
          else m_zrun = 0;
          if (m_zrun == D) begin
            m_armed = 1'b1;
            m_zrun  = 0;
          end
        end
      end
    end
  end

  // Compare process: every cycle out of reset, DUT vs model; also counts events.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("cmp_valid", {3'b0, valid}, {3'b0, m_valid});
        chk("cmp_code",  {2'b0, code},  {2'b0, m_code});
        chk("cmp_multi", {3'b0, multi}, {3'b0, m_multi});
        if (valid && !pv) ev++;
        pv = valid;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_valid: got valid=0 expected 1 within %0d cycles", max);
    end
  endtask

  initial begin : stim
    int e0;
    rst_n = 1'b0;
    keys  = 4'd0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {3'b0, valid}, 4'd0);
    chk("rst_code",  {2'b0, code},  4'd0);
    chk("rst_multi", {3'b0, multi}, 4'd0);
    rst_n = 1'b1;

    // Single key held, ready high: valid exactly after edge 7, one event.
    keys = 4'b0100; ready = 1'b1; e0 = ev;
    tick(6); chk("t1_valid_e6", {3'b0, valid}, 4'd0);
    tick(1); chk("t1_valid_e7", {3'b0, valid}, 4'd1);
    chk("t1_code", {2'b0, code}, 4'd2);
    chk("t1_multi", {3'b0, multi}, 4'd0);
    tick(1); chk("t1_valid_e8", {3'b0, valid}, 4'd0);
    tick(20); chk("t1_events", 4'(ev - e0), 4'd1);
    keys = 4'd0; tick(10);

    // Bounce then settle on key 0.
    e0 = ev;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(2);
    end
    keys = 4'b0001; tick(12);
    chk("t2_events", 4'(ev - e0), 4'd1);
    chk("t2_code", {2'b0, code}, 4'd0);
    keys = 4'd0; tick(10);

    // Two keys pressed together.
    ready = 1'b0; keys = 4'b1010;
    wait_valid(20);
    chk("t3_code", {2'b0, code}, 4'd3);
    chk("t3_multi", {3'b0, multi}, 4'd1);
    ready = 1'b1; tick(1);
    keys = 4'd0; tick(10);

    // Pattern change mid-debounce restarts the count: valid after edge 10.
    keys = 4'b0001; tick(3);
    keys = 4'b0010; tick(6);
    chk("t4_valid_e9", {3'b0, valid}, 4'd0);
    tick(1); chk("t4_valid_e10", {3'b0, valid}, 4'd1);
    chk("t4_code", {2'b0, code}, 4'd1);
    chk("t4_multi", {3'b0, multi}, 4'd0);
    keys = 4'd0; tick(10);

    // Backpressure with keys released while presenting.
    ready = 1'b0; keys = 4'b1000;
    wait_valid(20);
    keys = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t5_hold_valid", {3'b0, valid}, 4'd1);
      chk("t5_hold_code", {2'b0, code}, 4'd3);
      chk("t5_hold_multi", {3'b0, multi}, 4'd0);
    end
    ready = 1'b1; tick(1);
    chk("t5_valid_drop", {3'b0, valid}, 4'd0);
    tick(10);

    // Async reset between edges while presenting.
    ready = 1'b0; keys = 4'b0110;
    wait_valid(20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {3'b0, valid}, 4'd0);
    chk("t6_rst_code", {2'b0, code}, 4'd0);
    chk("t6_rst_multi", {3'b0, multi}, 4'd0);
    keys = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    e0 = ev;
    tick(20); chk("t6_no_event", 4'(ev - e0), 4'd0);

    // Fresh debounce after reset still works.
    ready = 1'b1; keys = 4'b0001;
    tick(6); chk("t7_valid_e6", {3'b0, valid}, 4'd0);
    tick(1); chk("t7_valid_e7", {3'b0, valid}, 4'd1);
    chk("t7_code", {2'b0, code}, 4'd0);
    keys = 4'd0; tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
